// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch unit: FSM state encoding
// and default increment / interrupt vector constants.
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam int unsigned DEF_INSTR_BYTES = 4;
   localparam logic [31:0] DEF_IRQ_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC select: redirect > interrupt > accepted fetch > hold.
// Holding (next_address = pc) is the stall, since the PC register loads every edge.
module next_pc_mux
   import mips_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_BYTES = DEF_INSTR_BYTES,
   parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = ADDR_WIDTH'(DEF_IRQ_VECTOR)
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  take_redirect,
   input  logic                  take_irq,
   input  logic                  take_ack,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] next_address
);

   logic [ADDR_WIDTH-1:0] seq_pc;

   // Sequential increment wraps modulo 2^ADDR_WIDTH with no overflow flag.
   assign seq_pc = pc + ADDR_WIDTH'(INSTR_BYTES);

   always_comb begin
      next_address = pc;
      if (take_redirect)
         next_address = redirect_target;
      else if (take_irq)
         next_address = IRQ_VECTOR;
      else if (take_ack)
         next_address = seq_pc;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit wrapped around the external PC register: fetches at pc
// over req/ack, presents the word to decode over valid/ready, handles redirects and interrupts.
module instruction_fetch
   import mips_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_BYTES = DEF_INSTR_BYTES,
   parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = ADDR_WIDTH'(DEF_IRQ_VECTOR)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] next_address,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   input  logic                  interrupt,
   output logic [ADDR_WIDTH-1:0] epc
);

   fetch_state_t state;
   logic         irq_pending;
   logic         in_fetch;
   logic         take_redirect;
   logic         take_irq;
   logic         take_ack;

   assign in_fetch      = (state == FETCH);
   assign take_redirect = redirect && (state != IDLE);
   assign take_irq      = in_fetch && irq_pending && !redirect;
   assign take_ack      = in_fetch && imem_ack && !redirect && !irq_pending;

   // Request drops combinationally on redirect/interrupt so the memory sees it abandoned.
   assign imem_req  = in_fetch && !redirect && !irq_pending;
   assign imem_addr = pc;

   next_pc_mux #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSTR_BYTES (INSTR_BYTES),
      .IRQ_VECTOR  (IRQ_VECTOR)
   ) u_next_pc_mux (
      .pc              (pc),
      .take_redirect   (take_redirect),
      .take_irq        (take_irq),
      .take_ack        (take_ack),
      .redirect_target (redirect_target),
      .next_address    (next_address)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         epc         <= '0;
         irq_pending <= 1'b0;
      end else begin
         // A level still high on the take cycle re-arms the pending flag.
         irq_pending <= (irq_pending && !take_irq) || interrupt;
         unique case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (take_irq) begin
                  epc <= pc;
               end else if (take_ack) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (redirect || instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the fetch/decode contract.
module tb_instruction_fetch;

   localparam logic [31:0] VEC = 32'h0000_0080;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc;
   logic [31:0] next_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        interrupt = 1'b0;
   logic [31:0] epc;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   instruction_fetch dut (
      .clock           (clock),
      .reset           (reset),
      .pc              (pc),
      .next_address    (next_address),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .interrupt       (interrupt),
      .epc             (epc)
   );

   // The program counter register the unit sits around: loads next_address every edge.
   always @(posedge clock or posedge reset) begin
      if (reset) pc <= '0;
      else       pc <= next_address;
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: started flag, "instruction held for decode" flag, pending interrupt.
   bit          m_run, m_hold, m_pend;
   logic [31:0] m_instr, m_ipc, m_epc;
   bit          nx_run, nx_hold, nx_pend;
   logic [31:0] nx_instr, nx_ipc, nx_epc;

   always @(negedge clock) begin
      logic [31:0] e_next;
      logic        e_req;
      if (reset) begin
         chk("rst_next", next_address, pc);
         chk("rst_req", imem_req, 0);
         chk("rst_valid", instr_valid, 0);
         chk("rst_instr", instr, 0);
         chk("rst_ipc", instr_pc, 0);
         chk("rst_epc", epc, 0);
         // If reset drops before the coming edge, that gap is the one idle cycle.
         nx_run = 1; nx_hold = 0; nx_pend = 0;
         nx_instr = '0; nx_ipc = '0; nx_epc = '0;
      end else begin
         nx_run = m_run; nx_hold = m_hold; nx_instr = m_instr;
         nx_ipc = m_ipc; nx_epc = m_epc;
         nx_pend = m_pend | interrupt;
         e_next = pc;
         e_req  = 0;
         if (!m_run) begin
            nx_run = 1;
         end else if (redirect) begin
            e_next  = redirect_target;
            nx_hold = 0;
         end else if (m_hold) begin
            if (instr_ready) nx_hold = 0;
         end else if (m_pend) begin
            e_next  = VEC;
            nx_epc  = pc;
            nx_pend = interrupt;
         end else begin
            e_req = 1;
            if (imem_ack) begin
               e_next   = pc + 32'd4;
               nx_instr = imem_rdata;
               nx_ipc   = pc;
               nx_hold  = 1;
            end
         end
         chk("next_address", next_address, e_next);
         chk("imem_req", imem_req, e_req);
         chk("imem_addr", imem_addr, pc);
         chk("instr_valid", instr_valid, m_hold);
         chk("instr", instr, m_instr);
         chk("instr_pc", instr_pc, m_ipc);
         chk("epc", epc, m_epc);
      end
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_run <= 0; m_hold <= 0; m_pend <= 0;
         m_instr <= '0; m_ipc <= '0; m_epc <= '0;
      end else begin
         m_run <= nx_run; m_hold <= nx_hold; m_pend <= nx_pend;
         m_instr <= nx_instr; m_ipc <= nx_ipc; m_epc <= nx_epc;
      end
   end

   task automatic cyc(input logic rd, input logic [31:0] tgt, input logic irq,
                      input logic rdy, input logic ack, input logic [31:0] data);
      @(posedge clock);
      #1;
      redirect        = rd;
      redirect_target = tgt;
      interrupt       = irq;
      instr_ready     = rdy;
      imem_rdata      = data;
      #1;
      imem_ack = ack;
      @(negedge clock);
   endtask

   localparam logic [31:0] D1  = 32'h2008_0005;
   localparam logic [31:0] D2  = 32'h8C43_0010;
   localparam logic [31:0] D3  = 32'h0123_4567;
   localparam logic [31:0] D4  = 32'hAC22_0004;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   initial begin
      repeat (2) @(negedge clock);
      chk("lit_rst_req", imem_req, 0);
      chk("lit_rst_valid", instr_valid, 0);
      chk("lit_rst_next", next_address, 32'h0);
      #1 reset = 1'b0;

      // Single fetch with same-cycle ack.
      cyc(0, 0, 0, 1, 1, D1);
      chk("lit_f1_req", imem_req, 1);
      chk("lit_f1_addr", imem_addr, 32'h0);
      chk("lit_f1_next", next_address, 32'h4);
      cyc(0, 0, 0, 1, 0, 0);
      chk("lit_f1_valid", instr_valid, 1);
      chk("lit_f1_instr", instr, D1);
      chk("lit_f1_ipc", instr_pc, 32'h0);
      chk("lit_f1_pc", pc, 32'h4);

      // Memory wait states: three cycles without ack, then ack.
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1, 0, 0);
         chk("lit_wait_req", imem_req, 1);
         chk("lit_wait_addr", imem_addr, 32'h4);
         chk("lit_wait_next", next_address, 32'h4);
         chk("lit_wait_valid", instr_valid, 0);
      end
      cyc(0, 0, 0, 1, 1, D2);
      chk("lit_wait_ackreq", imem_req, 1);
      chk("lit_wait_acknext", next_address, 32'h8);

      // Decode backpressure.
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk("lit_bp_valid", instr_valid, 1);
         chk("lit_bp_instr", instr, D2);
         chk("lit_bp_ipc", instr_pc, 32'h4);
         chk("lit_bp_req", imem_req, 0);
         chk("lit_bp_next", next_address, 32'h8);
      end

      // Redirect in HOLD, then redirect in FETCH with a same-cycle ack.
      cyc(1, 32'h400, 0, 0, 0, 0);
      chk("lit_rh_next", next_address, 32'h400);
      chk("lit_rh_req", imem_req, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("lit_rh_valid", instr_valid, 0);
      chk("lit_rh_addr", imem_addr, 32'h400);
      chk("lit_rh_req2", imem_req, 1);
      cyc(1, 32'h20, 0, 1, 1, BAD);
      chk("lit_rf_next", next_address, 32'h20);
      chk("lit_rf_req", imem_req, 0);
      cyc(0, 0, 0, 1, 1, D3);
      chk("lit_rf_valid", instr_valid, 0);
      chk("lit_rf_instr", instr, D2);
      chk("lit_rf_addr", imem_addr, 32'h20);
      chk("lit_rf_next2", next_address, 32'h24);

      // Interrupt pulse in HOLD at pc 0x24.
      cyc(0, 0, 1, 1, 0, 0);
      chk("lit_irq_hold_pc", pc, 32'h24);
      chk("lit_irq_hold_instr", instr, D3);
      chk("lit_irq_hold_ipc", instr_pc, 32'h20);
      cyc(0, 0, 0, 1, 1, BAD);
      chk("lit_irq_next", next_address, VEC);
      chk("lit_irq_req", imem_req, 0);

      // Interrupt together with redirect: redirect first, interrupt on following FETCH.
      cyc(1, 32'h100, 1, 1, 0, 0);
      chk("lit_irq_epc", epc, 32'h24);
      chk("lit_ir_next", next_address, 32'h100);
      chk("lit_ir_req", imem_req, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("lit_ir_next2", next_address, VEC);
      chk("lit_ir_epc_old", epc, 32'h24);

      // PC wrap.
      cyc(1, 32'hFFFF_FFFC, 0, 1, 0, 0);
      chk("lit_ir_epc", epc, 32'h100);
      cyc(0, 0, 0, 1, 1, D4);
      chk("lit_wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("lit_wrap_next", next_address, 32'h0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("lit_wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      chk("lit_wrap_pc", pc, 32'h0);

      // Asynchronous reset in the middle of a FETCH cycle.
      @(posedge clock);
      #1;
      instr_ready = 0;
      imem_ack    = 0;
      #1;
      chk("lit_ar_req_before", imem_req, 1);
      reset = 1'b1;
      #1;
      chk("lit_ar_req", imem_req, 0);
      chk("lit_ar_valid", instr_valid, 0);
      @(negedge clock);
      #1 reset = 1'b0;

      // Randomized traffic, including occasional mid-cycle resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock);
         #1;
         redirect        = ($urandom % 8) == 0;
         redirect_target = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         interrupt       = ($urandom % 20) == 0;
         instr_ready     = ($urandom % 2) == 0;
         imem_rdata      = $urandom;
         #1;
         imem_ack = imem_req && (($urandom % 3) == 0);
         if (($urandom % 400) == 0) begin
            #1 reset = 1'b1;
            @(negedge clock);
            #1 reset = 1'b0;
         end
      end

      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
